// File: rtl/sobel_frame_sequencer_if.sv
// Handshake, memory-strobe and kernel-control bundle for sobel_frame_sequencer.
// The slave modport is the sequencer side. The master modport is the datapath/bench side.
interface sobel_frame_sequencer_if #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
);
  localparam int unsigned AW = $clog2(IMG_W * IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic          start_i;
  logic          abort_i;
  logic          mode_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          img_wr_o;
  logic [AW-1:0] img_addr_o;
  logic          g_clr_o;
  logic          kernel_en_o;
  logic [RW-1:0] win_row_o;
  logic [CW-1:0] win_col_o;
  logic          kernel_done_i;
  logic          g_wr_o;
  logic [AW-1:0] g_addr_o;
  logic          out_sel_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;

  modport slave (
    input  start_i, abort_i, mode_i, in_valid_i, kernel_done_i, out_ready_i,
    output in_ready_o, img_wr_o, img_addr_o, g_clr_o, kernel_en_o, win_row_o,
           win_col_o, g_wr_o, g_addr_o, out_sel_o, out_valid_o, out_last_o,
           busy_o, done_o
  );

  modport master (
    output start_i, abort_i, mode_i, in_valid_i, kernel_done_i, out_ready_i,
    input  in_ready_o, img_wr_o, img_addr_o, g_clr_o, kernel_en_o, win_row_o,
           win_col_o, g_wr_o, g_addr_o, out_sel_o, out_valid_o, out_last_o,
           busy_o, done_o
  );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer for the Sobel datapath. Each accepted start request runs one
// sequence of clear, pixel load, 3x3 window walk and result drain.
module sobel_frame_sequencer #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sobel_frame_sequencer_if.slave sq_if
);
  localparam int unsigned AW = $clog2(IMG_W * IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  localparam logic [AW-1:0] LAST_PIX = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] LAST_WIN = AW'((IMG_W - 2) * (IMG_H - 2) - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 3);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_CALC, S_STORE, S_DRAIN
  } state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;   // load count in LOAD, read address in DRAIN
  logic [AW-1:0] win_q;    // running window index, row*(IMG_W-2)+col
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          mode_q;
  logic          start_q;
  logic          done_q;

  logic start_rise;
  logic drain_last;

  assign start_rise = sq_if.start_i && !start_q;
  assign drain_last = (addr_q == (mode_q ? LAST_PIX : LAST_WIN));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      win_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= sq_if.start_i;
      done_q  <= 1'b0;
      if (sq_if.abort_i) begin
        state_q <= S_IDLE;
        addr_q  <= '0;
        win_q   <= '0;
        row_q   <= '0;
        col_q   <= '0;
      end else begin
        case (state_q)
          // done_q still high means the FSM only just left DRAIN; such an edge belongs to that frame
          S_IDLE: begin
            if (start_rise && !done_q) begin
              state_q <= S_CLEAR;
              mode_q  <= sq_if.mode_i;
            end
          end
          S_CLEAR: begin
            addr_q  <= '0;
            win_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_LOAD;
          end
          S_LOAD: begin
            if (sq_if.in_valid_i) begin
              if (addr_q == LAST_PIX) begin
                addr_q  <= '0;
                state_q <= mode_q ? S_DRAIN : S_CALC;
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
          end
          S_CALC: begin
            if (sq_if.kernel_done_i) state_q <= S_STORE;
          end
          S_STORE: begin
            if (col_q == LAST_COL) begin
              col_q <= '0;
              if (row_q == LAST_ROW) begin
                row_q   <= '0;
                win_q   <= '0;
                state_q <= S_DRAIN;
              end else begin
                row_q   <= row_q + 1'b1;
                win_q   <= win_q + 1'b1;
                state_q <= S_CALC;
              end
            end else begin
              col_q   <= col_q + 1'b1;
              win_q   <= win_q + 1'b1;
              state_q <= S_CALC;
            end
          end
          S_DRAIN: begin
            if (sq_if.out_ready_i) begin
              if (drain_last) begin
                addr_q  <= '0;
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    sq_if.in_ready_o  = (state_q == S_LOAD);
    sq_if.img_wr_o    = (state_q == S_LOAD) && sq_if.in_valid_i;
    sq_if.img_addr_o  = '0;
    sq_if.g_addr_o    = '0;
    if (state_q == S_LOAD || (state_q == S_DRAIN && mode_q)) sq_if.img_addr_o = addr_q;
    if (state_q == S_STORE) sq_if.g_addr_o = win_q;
    else if (state_q == S_DRAIN && !mode_q) sq_if.g_addr_o = addr_q;
    sq_if.g_clr_o     = (state_q == S_CLEAR);
    sq_if.kernel_en_o = (state_q == S_CALC);
    sq_if.win_row_o   = row_q;
    sq_if.win_col_o   = col_q;
    sq_if.g_wr_o      = (state_q == S_STORE);
    sq_if.out_sel_o   = (state_q == S_DRAIN) && mode_q;
    sq_if.out_valid_o = (state_q == S_DRAIN);
    sq_if.out_last_o  = (state_q == S_DRAIN) && drain_last;
    sq_if.busy_o      = (state_q != S_IDLE);
    sq_if.done_o      = done_q;
  end
endmodule
